// File: rtl/fpr_wb_scoreboard_if.sv
// Bundle of issue, writeback-source and register-file write-port signals
// shared between the FP scoreboard and its surroundings.
interface fpr_wb_scoreboard_if #(
    parameter int NREG = 32,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    // ID stage
    logic            issue_valid_i;
    logic [2:0]      issue_rs_en_i;
    logic [AW-1:0]   issue_rs1_i;
    logic [AW-1:0]   issue_rs2_i;
    logic [AW-1:0]   issue_rs3_i;
    logic            issue_rd_en_i;
    logic [AW-1:0]   issue_rd_i;
    logic            issue_ready_o;

    // FPU result source
    logic            fpu_valid_i;
    logic [AW-1:0]   fpu_rd_i;
    logic [DW-1:0]   fpu_data_i;
    logic            fpu_ready_o;

    // LSU load source
    logic            lsu_valid_i;
    logic [AW-1:0]   lsu_rd_i;
    logic [DW-1:0]   lsu_data_i;
    logic            lsu_ready_o;

    // Register-file write port and status
    logic            we_o;
    logic [AW-1:0]   waddr_o;
    logic [DW-1:0]   wdata_o;
    logic [NREG-1:0] busy_o;
    logic            err_o;

    modport slave (
        input  issue_valid_i, issue_rs_en_i, issue_rs1_i, issue_rs2_i, issue_rs3_i,
        input  issue_rd_en_i, issue_rd_i,
        output issue_ready_o,
        input  fpu_valid_i, fpu_rd_i, fpu_data_i,
        output fpu_ready_o,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_ready_o,
        output we_o, waddr_o, wdata_o, busy_o, err_o
    );

    modport master (
        output issue_valid_i, issue_rs_en_i, issue_rs1_i, issue_rs2_i, issue_rs3_i,
        output issue_rd_en_i, issue_rd_i,
        input  issue_ready_o,
        output fpu_valid_i, fpu_rd_i, fpu_data_i,
        input  fpu_ready_o,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_ready_o,
        input  we_o, waddr_o, wdata_o, busy_o, err_o
    );
endinterface

// File: rtl/fpr_wb_scoreboard.sv
// FP register hazard scoreboard (RAW/WAW stall) plus round-robin arbiter
// sharing the register file's single registered write port between FPU and LSU.
module fpr_wb_scoreboard #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fpr_wb_scoreboard_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            rr_ptr_reg;
    logic            rr_ptr_next;
    logic            we_reg;
    logic [AW-1:0]   waddr_reg;
    logic [DW-1:0]   wdata_reg;
    logic            err_reg;

    logic [AW-1:0]   rs_addr [3];
    logic [2:0]      raw;
    logic            waw;
    logic            issue_ready;
    logic            issue_set;

    logic            fpu_grant;
    logic            lsu_grant;
    logic            wb_grant;
    logic [AW-1:0]   wb_rd;
    logic [DW-1:0]   wb_data;
    logic            wb_err;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign rs_addr[0] = bus.issue_rs1_i;
    assign rs_addr[1] = bus.issue_rs2_i;
    assign rs_addr[2] = bus.issue_rs3_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_raw
            assign raw[gi] = bus.issue_rs_en_i[gi]
                          && busy_reg[rs_addr[gi]]
                          && (rs_addr[gi] != '0);
        end
    endgenerate

    assign waw = bus.issue_rd_en_i
              && busy_reg[bus.issue_rd_i]
              && (bus.issue_rd_i != '0);

    assign issue_ready = !((|raw) || waw);

    // Only an instruction that actually fires and writes a non-zero rd claims it
    assign issue_set = bus.issue_valid_i && issue_ready && bus.issue_rd_en_i
                    && (bus.issue_rd_i != '0);

    // ------------------------------------------------------------------
    // Writeback arbitration: rr_ptr_reg=0 favours FPU, 1 favours LSU
    // ------------------------------------------------------------------
    assign fpu_grant = !rst && bus.fpu_valid_i && (!bus.lsu_valid_i || !rr_ptr_reg);
    assign lsu_grant = !rst && bus.lsu_valid_i && (!bus.fpu_valid_i ||  rr_ptr_reg);
    assign wb_grant  = fpu_grant || lsu_grant;

    assign wb_rd   = lsu_grant ? bus.lsu_rd_i   : bus.fpu_rd_i;
    assign wb_data = lsu_grant ? bus.lsu_data_i : bus.fpu_data_i;

    // Pointer only moves on real contention so a lone source never steals a turn
    assign rr_ptr_next = (bus.fpu_valid_i && bus.lsu_valid_i) ? ~rr_ptr_reg : rr_ptr_reg;

    // Writing back a register nobody is waiting on means a lost or duplicated result
    assign wb_err = wb_grant && (wb_rd != '0) && !busy_reg[wb_rd];

    // ------------------------------------------------------------------
    // Per-register busy update; set wins over clear
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue_set && (bus.issue_rd_i == AW'(gi));
                assign clr_bit = wb_grant  && (wb_rd == AW'(gi));
                assign busy_next[gi] = set_bit ? 1'b1
                                     : clr_bit ? 1'b0
                                     : busy_reg[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg   <= '0;
            rr_ptr_reg <= 1'b0;
            we_reg     <= 1'b0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            busy_reg   <= busy_next;
            rr_ptr_reg <= rr_ptr_next;
            we_reg     <= wb_grant;
            if (wb_grant) begin
                waddr_reg <= wb_rd;
                wdata_reg <= wb_data;
            end
            if (wb_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.fpu_ready_o   = fpu_grant;
    assign bus.lsu_ready_o   = lsu_grant;
    assign bus.we_o          = we_reg;
    assign bus.waddr_o       = waddr_reg;
    assign bus.wdata_o       = wdata_reg;
    assign bus.busy_o        = busy_reg;
    assign bus.err_o         = err_reg;
endmodule
